// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: buttons/graphics-side signals of the Pong game sequencer.
interface pong_game_ctrl_if;
    logic       refresh_tick;
    logic       start;
    logic       miss_l;
    logic       miss_r;
    logic [2:0] state;
    logic       ball_run;
    logic       ball_serve;
    logic       serve_dir;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [1:0] winner;
    logic       show_text;
    modport master (
        input  refresh_tick, start, miss_l, miss_r,
        output state, ball_run, ball_serve, serve_dir, score1, score2, winner, show_text
    );
    modport slave (
        output refresh_tick, start, miss_l, miss_r,
        input  state, ball_run, ball_serve, serve_dir, score1, score2, winner, show_text
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong match sequencer (title, serve countdown, play, point pause, game over) and scorekeeper.
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 9,
    parameter int PAUSE_FRAMES = 60
) (
    input logic clk,
    input logic reset,
    pong_game_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, POINT = 3'd3, OVER = 3'd4} state_t;
    localparam logic [7:0] LOAD = 8'(PAUSE_FRAMES - 1);
    localparam logic [3:0] WIN  = 4'(WIN_SCORE);
    state_t     st, nst;
    logic [3:0] s1, s2, ns1, ns2;
    logic [1:0] win, nwin;
    logic [7:0] timer, ntimer;
    logic       dir, ndir, serve, nserve, start_q;
    logic       start_edge;
    assign start_edge = bus.start & ~start_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            st      <= IDLE;
            s1      <= 4'd0;
            s2      <= 4'd0;
            win     <= 2'd0;
            timer   <= 8'd0;
            dir     <= 1'b1;
            serve   <= 1'b0;
            start_q <= 1'b1;
        end else begin
            st      <= nst;
            s1      <= ns1;
            s2      <= ns2;
            win     <= nwin;
            timer   <= ntimer;
            dir     <= ndir;
            serve   <= nserve;
            start_q <= bus.start;
        end
    end
    always_comb begin
        nst    = st;
        ns1    = s1;
        ns2    = s2;
        nwin   = win;
        ntimer = timer;
        ndir   = dir;
        nserve = 1'b0;
        case (st)
            IDLE: if (start_edge) begin
                ns1    = 4'd0;
                ns2    = 4'd0;
                nwin   = 2'd0;
                ndir   = 1'b1;
                nserve = 1'b1;
                ntimer = LOAD;
                nst    = SERVE;
            end
            SERVE, POINT: if (bus.refresh_tick) begin
                if (timer == 8'd0) begin
                    nst    = (st == SERVE) ? PLAY : SERVE;
                    nserve = (st == POINT);
                    ntimer = LOAD;
                end else begin
                    ntimer = timer - 8'd1;
                end
            end
            PLAY: if (bus.miss_l) begin
                ns2    = s2 + 4'd1;
                ndir   = 1'b0;
                nwin   = (ns2 == WIN) ? 2'd2 : win;
                nst    = (ns2 == WIN) ? OVER : POINT;
                ntimer = LOAD;
            end else if (bus.miss_r) begin
                ns1    = s1 + 4'd1;
                ndir   = 1'b1;
                nwin   = (ns1 == WIN) ? 2'd1 : win;
                nst    = (ns1 == WIN) ? OVER : POINT;
                ntimer = LOAD;
            end
            OVER: if (start_edge) nst = IDLE;
            default: nst = IDLE;
        endcase
    end
    assign bus.state      = st;
    assign bus.ball_run   = (st == PLAY);
    assign bus.ball_serve = serve;
    assign bus.serve_dir  = dir;
    assign bus.score1     = s1;
    assign bus.score2     = s2;
    assign bus.winner     = win;
    assign bus.show_text  = (st == IDLE) || (st == OVER);
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed match sequence with WIN_SCORE=2, PAUSE_FRAMES=3 against a per-cycle expectation queue.
module tb_pong_game_ctrl;
    localparam logic [2:0] IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, POINT = 3'd3, OVER = 3'd4;
    typedef struct packed {
        logic [2:0] st;
        logic       run, serve, dir, txt;
        logic [3:0] s1, s2;
        logic [1:0] win;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t  eq[$];
    string tq[$];
    pong_game_ctrl_if bus ();
    pong_game_ctrl #(.WIN_SCORE(2), .PAUSE_FRAMES(3)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input string f, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, f, obs, exp);
        end
    endtask
    task automatic cyc(input logic rs, input logic tk, input logic sb, input logic ml, input logic mr,
                       input string tag, input logic [2:0] est, input logic eserve, input logic edir,
                       input logic [3:0] es1, input logic [3:0] es2, input logic [1:0] ewin);
        exp_t e;
        reset = rs;
        bus.refresh_tick = tk;
        bus.start = sb;
        bus.miss_l = ml;
        bus.miss_r = mr;
        e = '{est, est == PLAY, eserve, edir, est == IDLE || est == OVER, es1, es2, ewin};
        eq.push_back(e);
        tq.push_back(tag);
        @(posedge clk);
        #1;
        e = eq.pop_front();
        tag = tq.pop_front();
        chk(tag, "state", {1'b0, bus.state}, {1'b0, e.st});
        chk(tag, "ball_run", {3'b0, bus.ball_run}, {3'b0, e.run});
        chk(tag, "ball_serve", {3'b0, bus.ball_serve}, {3'b0, e.serve});
        chk(tag, "serve_dir", {3'b0, bus.serve_dir}, {3'b0, e.dir});
        chk(tag, "show_text", {3'b0, bus.show_text}, {3'b0, e.txt});
        chk(tag, "score1", bus.score1, e.s1);
        chk(tag, "score2", bus.score2, e.s2);
        chk(tag, "winner", {2'b0, bus.winner}, {2'b0, e.win});
    endtask
    initial begin
        bus.refresh_tick = 1'b0;
        bus.start = 1'b1;
        bus.miss_l = 1'b0;
        bus.miss_r = 1'b0;
        cyc(1, 0, 1, 0, 0, "rst0", IDLE, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, "rst1", IDLE, 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, i[0], 1, i[1], i[2], "held", IDLE, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, "release", IDLE, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, "press", SERVE, 1, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, "serve_one", SERVE, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, "tick1", SERVE, 0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 1, "tick2", SERVE, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, "tick3", PLAY, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, "play", PLAY, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, "both_miss", POINT, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, "pt_t1", POINT, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 1, "pt_t2", POINT, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, "pt_wait", POINT, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, "pt_t3", SERVE, 1, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, "sv2_t1", SERVE, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, "sv2_t2", SERVE, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, "sv2_t3", PLAY, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, "miss_r1", POINT, 0, 1, 1, 1, 0);
        cyc(0, 1, 0, 0, 0, "pt2_t1", POINT, 0, 1, 1, 1, 0);
        cyc(0, 1, 0, 0, 0, "pt2_t2", POINT, 0, 1, 1, 1, 0);
        cyc(0, 1, 0, 0, 0, "pt2_t3", SERVE, 1, 1, 1, 1, 0);
        cyc(0, 1, 0, 0, 0, "sv3_t1", SERVE, 0, 1, 1, 1, 0);
        cyc(0, 1, 0, 0, 0, "sv3_t2", SERVE, 0, 1, 1, 1, 0);
        cyc(0, 1, 0, 0, 0, "sv3_t3", PLAY, 0, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 1, "win_p1", OVER, 0, 1, 2, 1, 1);
        cyc(0, 1, 0, 1, 1, "over_hold", OVER, 0, 1, 2, 1, 1);
        cyc(0, 0, 1, 0, 0, "over_start", IDLE, 0, 1, 2, 1, 1);
        cyc(0, 0, 1, 0, 0, "idle_held", IDLE, 0, 1, 2, 1, 1);
        cyc(0, 0, 0, 0, 0, "idle_rel", IDLE, 0, 1, 2, 1, 1);
        cyc(0, 0, 1, 0, 0, "restart", SERVE, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, "r_t1", SERVE, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, "r_t2", SERVE, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, "r_t3", PLAY, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, "r_miss_l", POINT, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, "r_pt_t1", POINT, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0, "mid_reset", IDLE, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, "post_reset", IDLE, 0, 1, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game sequencer for the Pong display pipeline. It sits between the player buttons and the graphics generator, and owns the match flow: idle/title screen, serve countdown, live play, post-point pause, and game over. It counts frames on the 60 Hz refresh tick, keeps both scores, and tells the graphics generator when the ball may move and when to re-centre it. The graphics generator reports each wall miss and draws from this block's outputs; it no longer keeps scores of its own.

## Interface
- WIN_SCORE, 9: points needed to win; legal range 1..15.
- PAUSE_FRAMES, 60: length of the serve countdown and of the post-point pause, in refresh ticks; legal range 1..255.
- clk  in  1  pixel/system clock.
- reset  in  1  synchronous, active-high; one clock domain only.
- refresh_tick  in  1  one-cycle pulse per frame at the start of vertical retrace.
- start  in  1  start button level, already synchronized and debounced upstream; acted on at rising edge only.
- miss_l  in  1  one-cycle pulse: ball reached the left wall (player 1 conceded).
- miss_r  in  1  one-cycle pulse: ball reached the right wall (player 2 conceded).
- state  out  3  current state: 0 IDLE, 1 SERVE, 2 PLAY, 3 POINT, 4 OVER.
- ball_run  out  1  ball motion enable; 1 only in PLAY.
- ball_serve  out  1  one-cycle pulse: load the ball at screen centre.
- serve_dir  out  1  initial x direction for the next serve; 1 = rightward, 0 = leftward.
- score1, score2  out  4 each  player scores.
- winner  out  2  0 none, 1 player 1, 2 player 2.
- show_text  out  1  title/"game over" text enable; 1 in IDLE and OVER.

## Operation
- start_edge = start & ~start_q, where start_q is start registered by one cycle.
- Internal 8-bit timer counts ticks in SERVE and POINT.
  - Load value on entry to either state: PAUSE_FRAMES-1.
  - On refresh_tick: if timer == 0, leave the state; otherwise decrement.
  - The state therefore lasts exactly PAUSE_FRAMES ticks. A tick in the entry cycle counts.
- IDLE
  - start_edge: clear score1, score2 and winner; set serve_dir=1; pulse ball_serve; load timer; go to SERVE.
- SERVE
  - Ball is held (ball_run=0).
  - Timer expiry: go to PLAY.
- PLAY
  - ball_run=1.
  - miss_l: score2 +1; serve_dir=0.
  - miss_r (only when miss_l is low): score1 +1; serve_dir=1. If both pulse in the same cycle, miss_l wins and miss_r is dropped.
  - After a miss, if the incremented score == WIN_SCORE: set winner and go to OVER. Otherwise load timer and go to POINT.
- POINT
  - Ball is frozen where it missed.
  - Timer expiry: pulse ball_serve, reload timer, go to SERVE.
- OVER
  - Scores and winner hold.
  - start_edge: go to IDLE with scores unchanged. The next start_edge clears them.
- Ignored inputs
  - miss_l/miss_r outside PLAY have no effect.
  - start_edge outside IDLE/OVER has no effect.
  - refresh_tick outside SERVE/POINT has no effect.
- Width rules
  - Scores are 4-bit and can never exceed WIN_SCORE, because OVER is entered at equality. No wrap logic is needed.
  - Timer width is 8 bits.

## Timing
- All outputs are registered, changing on the clk edge after the causing input cycle (latency 1).
- ball_serve is high for exactly one cycle: the first cycle of SERVE.
- ball_run falls in the same cycle that state leaves PLAY. The ball never advances on the frame following a miss.
- Reset values:
  - state=IDLE; score1=score2=0; winner=0.
  - ball_run=0; ball_serve=0; serve_dir=1; show_text=1; timer=0.
  - start_q=1, so a button held through reset does not start a game.
- Reset mid-game (any state) returns to the reset values on the next edge. Any in-flight timer or ball_serve is cancelled.
- WIN_SCORE=1: the first miss goes straight to OVER.
- PAUSE_FRAMES=1: the first tick after entry exits.

## Test plan
- Reset with start held high, then keep start high 10 cycles → state stays IDLE, all outputs at reset values; release and re-press start → state=SERVE and ball_serve=1 for one cycle, exactly one cycle after the press.
- In SERVE with PAUSE_FRAMES=3, issue ticks → state=PLAY after the 3rd tick, ball_run=1 the next cycle; miss pulses before that leave scores at 0.
- In PLAY, pulse miss_l → score2=1, serve_dir=0, state=POINT, ball_run=0; after 3 ticks ball_serve pulses and state=SERVE.
- miss_l and miss_r in the same PLAY cycle → only score2 increments; score1 unchanged.
- With WIN_SCORE=2, play two miss_r points → score1=2, winner=1, state=OVER, show_text=1; start edge → IDLE with score1=2 held; second start edge → scores and winner cleared, state=SERVE.
- Assert reset while in POINT with timer mid-count → next cycle state=IDLE, scores=0, no ball_serve pulse afterward.
